// File: rtl/tinyalu_pkg.sv
// Shared TinyALU definitions: opcode encoding, datapath widths and opcode legality check.
package tinyalu_pkg;

  localparam int unsigned OPCODE_W  = 3;
  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned RESULT_W  = 16;
  // One queued command: {opcode, operand A, operand B}.
  localparam int unsigned CMD_W     = OPCODE_W + 2 * OPERAND_W;

  typedef enum logic [OPCODE_W-1:0] {
    OpNoOp = 3'b000,
    OpAdd  = 3'b001,
    OpAnd  = 3'b010,
    OpXor  = 3'b011,
    OpMul  = 3'b100
  } alu_op_e;

  function automatic logic is_legal_op(input logic [OPCODE_W-1:0] code);
    return code <= OpMul;
  endfunction

endpackage

// File: rtl/tinyalu_op_fifo.sv
// Synchronous command FIFO with occupancy count; pushes while full and pops while empty are ignored.
module tinyalu_op_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 19
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wptr_q;
  logic [AddrW-1:0] rptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == (AddrW + 1)'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (do_pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (do_push != do_pop) begin
        count_q <= do_push ? count_q + 1'b1 : count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/tinyalu_cmd_issuer.sv
// TinyALU command issuer: queues ops, runs the start/done handshake and holds each result on a
// valid/ready stream. Defining TINYALU_ISSUER_TIMEOUT_EN adds a watchdog on the BUSY state.
module tinyalu_cmd_issuer
  import tinyalu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [2:0]  op_code,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic [2:0]  res_op,
  output logic        bad_op,
  output logic        timeout
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e                  state_q;
  logic                    alu_start_q;
  logic [OPCODE_W-1:0]     alu_op_q;
  logic [OPERAND_W-1:0]    alu_a_q;
  logic [OPERAND_W-1:0]    alu_b_q;
  logic                    res_valid_q;
  logic [RESULT_W-1:0]     res_data_q;
  logic [OPCODE_W-1:0]     res_op_q;
  logic                    bad_op_q;

  logic [CMD_W-1:0]        fifo_wdata;
  logic [CMD_W-1:0]        fifo_rdata;
  logic                    fifo_push;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] unused_fifo_count;
  logic [OPCODE_W-1:0]     head_op;
  logic [OPERAND_W-1:0]    head_a;
  logic [OPERAND_W-1:0]    head_b;
  logic                    res_free;
  logic                    tmo_expire;

  assign op_ready   = ~fifo_full;
  assign fifo_push  = op_valid & ~fifo_full;
  assign fifo_wdata = {op_code, op_a, op_b};
  assign {head_op, head_a, head_b} = fifo_rdata;

  // The result slot counts as free in the cycle it is being handed off downstream.
  assign res_free = ~res_valid_q | res_ready;
  assign fifo_pop = (state_q == StIdle) & ~fifo_empty & res_free;

  tinyalu_op_fifo #(
    .Depth (FIFO_DEPTH),
    .Width (CMD_W)
  ) u_op_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      alu_start_q <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      bad_op_q    <= 1'b0;
    end else begin
      bad_op_q <= 1'b0;
      if (res_valid_q && res_ready) begin
        res_valid_q <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (fifo_pop) begin
            if (!is_legal_op(head_op)) begin
              bad_op_q <= 1'b1;
            end else if (head_op != OpNoOp) begin
              alu_op_q    <= head_op;
              alu_a_q     <= head_a;
              alu_b_q     <= head_b;
              alu_start_q <= 1'b1;
              state_q     <= StBusy;
            end
          end
        end
        StBusy: begin
          // res_valid_q is always clear here: an op only issues once the slot is free.
          if (alu_done) begin
            res_data_q  <= alu_result;
            res_op_q    <= alu_op_q;
            res_valid_q <= 1'b1;
            alu_start_q <= 1'b0;
            state_q     <= StIdle;
          end else if (tmo_expire) begin
            alu_start_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef TINYALU_ISSUER_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYCLES - 1);

  logic [TmoW-1:0] tmo_cnt_q;
  logic            timeout_q;

  // Expiry on the last allowed BUSY cycle; a done in that same cycle takes priority.
  assign tmo_expire = (state_q == StBusy) & ~alu_done & (tmo_cnt_q == TmoLast);
  assign timeout    = timeout_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= tmo_expire;
      if (state_q != StBusy) begin
        tmo_cnt_q <= '0;
      end else if (!alu_done) begin
        tmo_cnt_q <= tmo_cnt_q + 1'b1;
      end
    end
  end
`else
  logic unused_timeout_cfg;

  assign tmo_expire         = 1'b0;
  assign timeout            = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  assign alu_start = alu_start_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_op    = res_op_q;
  assign bad_op    = bad_op_q;

endmodule

// File: tb/tb_tinyalu_cmd_issuer.sv
// Self-checking bench for tinyalu_cmd_issuer: vector table, directed corner sequences and a
// randomized phase checked against a queue-based model. Timeout tests need TINYALU_ISSUER_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_tinyalu_cmd_issuer;

  localparam int unsigned Depth     = 4;
  localparam int unsigned TmoCycles = 15;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [2:0]  op_code = '0;
  logic [7:0]  op_a = '0;
  logic [7:0]  op_b = '0;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done = 1'b0;
  logic [15:0] alu_result = '0;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [15:0] res_data;
  logic [2:0]  res_op;
  logic        bad_op;
  logic        timeout;

  always #5 clk = ~clk;

  tinyalu_cmd_issuer #(
    .FIFO_DEPTH     (Depth),
    .TIMEOUT_CYCLES (TmoCycles)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .op_valid   (op_valid),
    .op_ready   (op_ready),
    .op_code    (op_code),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_op     (res_op),
    .bad_op     (bad_op),
    .timeout    (timeout)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state: ops expected to reach the ALU, results expected downstream.
  logic [18:0] iss_q[$];
  logic [18:0] exp_q[$];
  int          bad_pending = 0;
  bit          accepted;
  int          acc_cyc, rise_cyc, run_len, last_run_len;
  int          res_count = 0, bad_seen = 0, tmo_seen = 0, rise_count = 0;
  logic [15:0] last_res_data;
  logic [2:0]  last_res_op;
  logic [18:0] cur_issue;
  bit          prev_start, prev_done_busy, prev_rv, prev_rr;
  logic [15:0] prev_result, prev_rdata;

  // Behavioural TinyALU: done arrives alu_lat cycles after start first goes high.
  int alu_lat = 1;
  int age = 0;
  bit mute = 0, force_done = 0, lat_rand = 0;

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
    case (op)
      3'b001:  return 16'(a) + 16'(b);
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return 16'(a) * 16'(b);
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flush_model();
    iss_q.delete();
    exp_q.delete();
    bad_pending = 0;
    prev_start = 0;
    prev_done_busy = 0;
    prev_rv = 0;
    prev_rr = 0;
  endtask

  task automatic monitor();
    logic [18:0] e;
    if (op_valid && op_ready) begin
      accepted = 1;
      acc_cyc = cyc;
      if (op_code >= 3'd5) begin
        bad_pending++;
      end else if (op_code != 3'd0) begin
        iss_q.push_back({op_code, op_a, op_b});
        exp_q.push_back({op_code, ref_result(op_code, op_a, op_b)});
      end
    end
    if (alu_start && !prev_start) begin
      rise_cyc = cyc;
      rise_count++;
      run_len = 1;
      cur_issue = {alu_op, alu_a, alu_b};
      check("issue_expected", iss_q.size() > 0, 1);
      if (iss_q.size() > 0) check("issue_cmd", cur_issue, iss_q.pop_front());
    end else if (alu_start) begin
      run_len++;
      check("operands_stable", {alu_op, alu_a, alu_b}, cur_issue);
    end
    if (prev_start && !alu_start) last_run_len = run_len;
    if (prev_done_busy) begin
      check("start_drop_after_done", alu_start, 0);
      check("res_valid_after_done", res_valid, 1);
      check("res_capture", res_data, prev_result);
    end
    if (prev_rv && !prev_rr) begin
      check("res_hold_valid", res_valid, 1);
      check("res_hold_data", res_data, prev_rdata);
    end
    if (res_valid && res_ready) begin
      res_count++;
      last_res_data = res_data;
      last_res_op = res_op;
      check("result_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("res_data", res_data, e[15:0]);
        check("res_op", res_op, e[18:16]);
      end
    end
    if (bad_op) begin
      bad_seen++;
      check("bad_op_expected", bad_pending > 0, 1);
      if (bad_pending > 0) bad_pending--;
    end
`ifdef TINYALU_ISSUER_TIMEOUT_EN
    if (timeout) begin
      tmo_seen++;
      check("timeout_start_low", alu_start, 0);
      check("timeout_run_len", last_run_len, TmoCycles);
      // Nothing else can be pending while BUSY, so the timed-out op is the oldest expected result.
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
`else
    check("timeout_tied_low", timeout, 0);
`endif
    prev_start = alu_start;
    prev_done_busy = alu_start && alu_done;
    prev_result = alu_result;
    prev_rv = res_valid;
    prev_rr = res_ready;
    prev_rdata = res_data;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc++;
    if (alu_start) age++;
    else age = 0;
    if (lat_rand && age == 1) alu_lat = $urandom_range(0, 3);
    alu_done = force_done || (alu_start && !mute && age == alu_lat + 1);
    alu_result = alu_done ? ref_result(alu_op, alu_a, alu_b) : 16'($urandom);
  endtask

  task automatic push_op(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    op_valid = 1;
    op_code = c;
    op_a = a;
    op_b = b;
    accepted = 0;
    for (int i = 0; i < 100 && !accepted; i++) tick();
    op_valid = 0;
    check("push_accepted", accepted, 1);
  endtask

  task automatic wait_results(input int n, input int bound);
    int target;
    int i;
    target = res_count + n;
    i = 0;
    while (res_count < target && i < bound) begin
      tick();
      i++;
    end
    check("results_arrived", res_count >= target, 1);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int          lat;
    logic [15:0] data;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int a0, b0, r0, s0, t0;
    vecs[0] = '{3'b001, 8'h12, 8'h34, 1, 16'h0046};
    vecs[1] = '{3'b100, 8'hFF, 8'hFF, 3, 16'hFE01};
    vecs[2] = '{3'b010, 8'hF0, 8'h3C, 2, 16'h0030};
    vecs[3] = '{3'b011, 8'hF0, 8'h0F, 0, 16'h00FF};
    vecs[4] = '{3'b001, 8'hFF, 8'h01, 1, 16'h0100};
    vecs[5] = '{3'b100, 8'h10, 8'h10, 4, 16'h0100};
    vecs[6] = '{3'b010, 8'hAA, 8'h55, 1, 16'h0000};
    vecs[7] = '{3'b011, 8'h5A, 8'hFF, 2, 16'h00A5};
    flush_model();

    // Reset state
    repeat (3) tick();
    reset_n = 1;
    res_ready = 1;
    tick();
    check("rst_alu_start", alu_start, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_op", res_op, 0);
    check("rst_bad_op", bad_op, 0);
    check("rst_timeout", timeout, 0);
    check("rst_op_ready", op_ready, 1);

    // Single-op vectors
    for (int i = 0; i < 8; i++) begin
      alu_lat = vecs[i].lat;
      push_op(vecs[i].op, vecs[i].a, vecs[i].b);
      a0 = acc_cyc;
      wait_results(1, 50);
      check("tbl_res_data", last_res_data, vecs[i].data);
      check("tbl_res_op", last_res_op, vecs[i].op);
      check("tbl_start_latency", rise_cyc - a0, 2);
      check("tbl_start_len", last_run_len, vecs[i].lat + 1);
      tick();
    end

    // no_op, illegal, xor
    b0 = bad_seen;
    r0 = res_count;
    s0 = rise_count;
    alu_lat = 1;
    push_op(3'b000, 8'h11, 8'h22);
    push_op(3'b110, 8'h33, 8'h44);
    push_op(3'b011, 8'hF0, 8'h0F);
    wait_results(1, 50);
    repeat (4) tick();
    check("mix_bad_op_pulses", bad_seen - b0, 1);
    check("mix_result_count", res_count - r0, 1);
    check("mix_result_data", last_res_data, 16'h00FF);
    check("mix_start_count", rise_count - s0, 1);

    // Backpressure: one result held, FIFO fills behind it
    res_ready = 0;
    r0 = res_count;
    s0 = rise_count;
    for (int i = 0; i < 5; i++) push_op(3'(1 + i % 4), 8'(i * 17 + 3), 8'(i + 5));
    op_valid = 1;
    op_code = 3'b001;
    op_a = 8'h77;
    op_b = 8'h01;
    repeat (3) tick();
    check("bp_op_ready_low", op_ready, 0);
    check("bp_res_held", res_valid, 1);
    check("bp_single_issue", rise_count - s0, 1);
    op_valid = 0;
    res_ready = 1;
    wait_results(5, 200);
    check("bp_all_delivered", res_count - r0, 5);
    repeat (2) tick();

    // Reset during BUSY, then a late spurious done
    mute = 1;
    push_op(3'b100, 8'hFF, 8'hFF);
    push_op(3'b001, 8'h01, 8'h02);
    for (int i = 0; i < 20 && !alu_start; i++) tick();
    check("rst_mid_busy", alu_start, 1);
    #2 reset_n = 0;
    #1;
    check("rst_mid_alu_start", alu_start, 0);
    check("rst_mid_res_valid", res_valid, 0);
    check("rst_mid_op_ready", op_ready, 1);
    flush_model();
    mute = 0;
    tick();
    tick();
    reset_n = 1;
    force_done = 1;
    tick();
    force_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_start", alu_start, 0);
      check("post_rst_no_result", res_valid, 0);
    end
    check("post_rst_fifo_empty", op_ready, 1);

`ifdef TINYALU_ISSUER_TIMEOUT_EN
    // Unresponsive ALU, then next queued op; then done on the expiry cycle
    mute = 1;
    alu_lat = 1;
    t0 = tmo_seen;
    r0 = res_count;
    push_op(3'b100, 8'h12, 8'h34);
    push_op(3'b001, 8'h03, 8'h04);
    for (int i = 0; i < 60 && tmo_seen == t0; i++) tick();
    mute = 0;
    check("tmo_pulse_once", tmo_seen - t0, 1);
    wait_results(1, 50);
    check("tmo_next_result", last_res_data, 16'h0007);
    check("tmo_result_count", res_count - r0, 1);
    alu_lat = TmoCycles - 1;
    push_op(3'b011, 8'hC3, 8'h0F);
    wait_results(1, 60);
    check("tmo_done_wins", tmo_seen - t0, 1);
    check("tmo_done_wins_data", last_res_data, 16'h00CC);
    repeat (2) tick();
`endif

    // Randomized traffic against the model
    lat_rand = 1;
    for (int i = 0; i < 400; i++) begin
      op_valid = ($urandom_range(0, 1) == 1);
      op_code = 3'($urandom_range(0, 7));
      op_a = 8'($urandom);
      op_b = 8'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    op_valid = 0;
    res_ready = 1;
    for (int i = 0; i < 300 && (iss_q.size() > 0 || exp_q.size() > 0); i++) tick();
    repeat (10) tick();
    check("drain_issue_q", iss_q.size(), 0);
    check("drain_result_q", exp_q.size(), 0);
    check("drain_bad_pending", bad_pending, 0);
    lat_rand = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tinyalu_cmd_issuer.md
Name: tinyalu_cmd_issuer

Overview:
Upstream RTL stage of the TinyALU datapath.
- Accepts operations on a valid/ready stream and buffers them in a small FIFO.
- Issues each operation to the TinyALU core using the start/done protocol.
- Captures the 16-bit result and presents it on a valid/ready result stream.
- Result semantics match the TLM ALU model: no_op produces no result; illegal opcodes are flagged and dropped.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT_CYCLES, 15, max cycles alu_start may stay high without alu_done (used only with the optional feature)

Ports:
clk  in  1  single clock, rising edge
reset_n  in  1  asynchronous active-low reset
op_valid  in  1  upstream op valid
op_ready  out  1  FIFO can accept; equals !fifo_full
op_code  in  3  alu_op_e encoding
op_a  in  8  operand A
op_b  in  8  operand B
alu_start  out  1  start to TinyALU, registered
alu_op  out  3  opcode to TinyALU, registered, stable while alu_start=1
alu_a  out  8  operand A to TinyALU, registered
alu_b  out  8  operand B to TinyALU, registered
alu_done  in  1  single-cycle completion pulse from TinyALU
alu_result  in  16  TinyALU result, valid when alu_done=1
res_valid  out  1  result register full
res_ready  in  1  downstream accepts result
res_data  out  16  captured result
res_op  out  3  opcode that produced res_data
bad_op  out  1  one-cycle pulse when an illegal opcode is dropped
timeout  out  1  one-cycle pulse on watchdog expiry (0 without the optional feature)

Behaviour:
- Reset values: all outputs 0, FSM=IDLE, FIFO empty, count=0. op_ready is therefore 1 once FIFO empty after reset.
- Encoding: no_op=000, add=001, and=010, xor=011, mul=100. Codes 101–111 are illegal.
- Input accept: push when op_valid & op_ready. No pass-through.
  - Full FIFO: op_ready=0 and op_valid is ignored.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Read/write pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, BUSY.
  - IDLE, FIFO non-empty, res_valid=0: pop the head entry.
    - Legal non-no_op: register alu_op/a/b, set alu_start=1, go to BUSY.
    - no_op: discard silently, stay IDLE.
    - Illegal opcode: discard, pulse bad_op next cycle, stay IDLE.
  - IDLE, res_valid=1: no pop; hold until the result register is empty.
  - BUSY: hold alu_start=1 with alu_op/a/b stable. When alu_done is sampled:
    - load res_data=alu_result and res_op=alu_op;
    - set res_valid=1 and alu_start=0, both visible the next cycle;
    - go to IDLE.
  - Guaranteed one-cycle minimum gap between consecutive alu_start pulses.
- Latency:
  - Op accepted in cycle N → alu_start first high in cycle N+2 (FIFO write at N, pop at N+1).
  - alu_done in cycle D → res_valid=1 and alu_start=0 in cycle D+1.
- Result handshake: res_valid clears on the edge where res_valid & res_ready. The next issue may pop in that same cycle, since free is evaluated as !res_valid | res_ready.
- alu_done while IDLE is spurious: ignore it, no state change.
- Reset asserted mid-operation: immediate clear. FIFO contents and in-flight op are lost; alu_start drops asynchronously.

Optional Feature:
Macro TINYALU_ISSUER_TIMEOUT_EN.
- Defined:
  - A cycle counter of width $clog2(TIMEOUT_CYCLES+1) resets on entry to BUSY and increments each BUSY cycle without alu_done.
  - When it reaches TIMEOUT_CYCLES: clear alu_start, pulse timeout for one cycle, return to IDLE, produce no result.
  - If alu_done arrives in the same cycle as expiry, done wins: result is captured, no timeout.
- Undefined: no counter; BUSY waits indefinitely; timeout tied to 0.

Decomposition:
- tinyalu_pkg holds the alu_op_e enum (3-bit), OPERAND_W=8, RESULT_W=16, and a function is_legal_op().
- One sub-module, tinyalu_op_fifo: synchronous FIFO parameterised by depth and 19-bit width, with full/empty/count outputs, asynchronous active-low reset.

Test Plan:
- add A=8'h12 B=8'h34, TinyALU done after 1 cycle → res_data=16'h0046, res_op=001, alu_start high exactly from N+2 until the cycle after done.
- mul A=8'hFF B=8'hFF, done after 3 cycles → res_data=16'hFE01; alu_a/alu_b stable throughout BUSY.
- Push no_op, code 3'b110, xor 8'hF0^8'h0F → bad_op pulses once, exactly one result 16'h00FF; no_op produces no alu_start.
- Hold res_ready=0, push 4+1 ops → op_ready=0 after 4 accepted while one result is held; release res_ready → all 5 results delivered in order, one-cycle start gap each.
- Assert reset_n=0 during BUSY for mul → alu_start, res_valid, op_ready-path reset immediately; after release, a late alu_done is ignored and FIFO is empty.
- With TINYALU_ISSUER_TIMEOUT_EN, TIMEOUT_CYCLES=15, TinyALU never responds → timeout pulses after 15 BUSY cycles, no result, next queued op is issued.
